// File: rtl/ysyx_23060201_isram.sv
// Instruction-memory responder: one fetch at a time, fixed latency.
// Define YSYX_23060201_ISRAM_RAND_DELAY_EN to add LFSR-driven extra wait.
module ysyx_23060201_isram #(
  parameter int unsigned DEPTH   = 1024,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int unsigned LATENCY = 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_inst,
  output logic          rsp_err,
  input  logic          ld_wen,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data
);

  localparam int CW = $clog2(LATENCY + 4) + 1;
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] wait_n;
  logic [31:0]   mem [DEPTH];
  logic [31:0]   off;
  logic          hit;

  // Offset from BASE; the 33-bit compare keeps the upper bound overflow-free.
  assign off = req_addr - BASE;
  assign hit = (req_addr >= BASE) &&
               ({1'b0, off} < SPAN) &&
               (req_addr[1:0] == 2'b00);

`ifdef YSYX_23060201_ISRAM_RAND_DELAY_EN
  logic [7:0] lfsr;

  // Free-running Fibonacci LFSR, taps 8,6,5,4.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= 8'hA5;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign wait_n = CW'(LATENCY - 1) + CW'(lfsr[1:0]);
`else
  assign wait_n = CW'(LATENCY - 1);
`endif

  // Preload port; array is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (ld_wen) begin
      mem[ld_addr] <= ld_data;
    end
  end

  // Request/response FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_inst  <= '0;
      rsp_err   <= 1'b0;
      cnt       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            rsp_inst  <= hit ? mem[off[AW+1:2]] : 32'h0;
            rsp_err   <= !hit;
            if (wait_n == '0) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= wait_n - CW'(1);
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060201_isram.sv
// Bench for ysyx_23060201_isram: two instances, LATENCY 1 and 3.
// Vector table plus scoreboard queue of expected responses.
module tb_ysyx_23060201_isram;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_addr [2];
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_inst [2];
  logic [1:0]  rsp_err;
  logic        ld_wen;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    int          k;
    logic [31:0] addr;
    logic [31:0] inst;
    logic        err;
    int          hold;
    logic        do_ld;
    logic [9:0]  la;
    logic [31:0] ld;
  } vec_t;

  vec_t        tv [12];
  logic [31:0] em [16];

  always #5 clk = ~clk;

  ysyx_23060201_isram #(.LATENCY(1)) u_l1 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid[0]),
    .req_ready (req_ready[0]),
    .req_addr  (req_addr[0]),
    .rsp_valid (rsp_valid[0]),
    .rsp_ready (rsp_ready[0]),
    .rsp_inst  (rsp_inst[0]),
    .rsp_err   (rsp_err[0]),
    .ld_wen    (ld_wen),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data)
  );

  ysyx_23060201_isram #(.LATENCY(3)) u_l3 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid[1]),
    .req_ready (req_ready[1]),
    .req_addr  (req_addr[1]),
    .rsp_valid (rsp_valid[1]),
    .rsp_ready (rsp_ready[1]),
    .rsp_inst  (rsp_inst[1]),
    .rsp_err   (rsp_err[1]),
    .ld_wen    (ld_wen),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_wen  = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(negedge clk);
    ld_wen  = 1'b0;
  endtask

  task automatic fetch(input int k, input logic [31:0] a,
                       input logic [31:0] ei, input logic ee,
                       input int hold, input logic do_ld,
                       input logic [9:0] la, input logic [31:0] ld);
    int          lat;
    int          lexp;
    exp_t        e;
    logic [31:0] held;
    lexp = (k == 0) ? 1 : 3;
    @(negedge clk);
    chk("idle_req_ready", 32'(req_ready[k]), 32'd1);
    chk("idle_rsp_valid", 32'(rsp_valid[k]), 32'd0);
    req_valid[k] = 1'b1;
    req_addr[k]  = a;
    ld_wen       = do_ld;
    ld_addr      = la;
    ld_data      = ld;
    sb.push_back('{inst: ei, err: ee});
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      req_valid[k] = 1'b0;
      ld_wen       = 1'b0;
      lat++;
      if (!rsp_valid[k])
        chk("busy_req_ready", 32'(req_ready[k]), 32'd0);
    end while (!rsp_valid[k] && lat < 64);
`ifdef YSYX_23060201_ISRAM_RAND_DELAY_EN
    n_chk++;
    if (lat < lexp || lat > lexp + 3) begin
      n_fail++;
      $display("FAIL latency: got %0d want %0d..%0d", lat, lexp, lexp + 3);
    end
`else
    chk("latency", 32'(lat), 32'(lexp));
`endif
    held = rsp_inst[k];
    repeat (hold) begin
      @(negedge clk);
      chk("hold_inst", rsp_inst[k], held);
      chk("hold_valid", 32'(rsp_valid[k]), 32'd1);
      chk("hold_req_ready", 32'(req_ready[k]), 32'd0);
    end
    e = sb.pop_front();
    chk("rsp_inst", rsp_inst[k], e.inst);
    chk("rsp_err", 32'(rsp_err[k]), 32'(e.err));
    rsp_ready[k] = 1'b1;
    @(posedge clk);
    #1 rsp_ready[k] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    req_addr[0] = '0;
    req_addr[1] = '0;
    ld_wen    = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd3);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_inst0", rsp_inst[0], 32'd0);
    chk("rst_inst1", rsp_inst[1], 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 16; i++)
      em[i] = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
    em[0] = 32'h0000_0413;
    em[1] = 32'h0010_0073;
    em[2] = 32'h1234_5678;
    for (int i = 0; i < 16; i++) preload(10'(i), em[i]);
    preload(10'd1023, 32'hCAFE_F00D);

    tv[0]  = '{0, 32'h8000_0000, 32'h0000_0413, 1'b0, 0, 1'b0, 10'd0, 32'h0};
    tv[1]  = '{1, 32'h8000_0004, 32'h0010_0073, 1'b0, 5, 1'b0, 10'd0, 32'h0};
    tv[2]  = '{0, 32'h8000_0002, 32'h0, 1'b1, 0, 1'b0, 10'd0, 32'h0};
    tv[3]  = '{0, 32'h7FFF_FFFC, 32'h0, 1'b1, 0, 1'b0, 10'd0, 32'h0};
    tv[4]  = '{0, 32'h8000_1000, 32'h0, 1'b1, 1, 1'b0, 10'd0, 32'h0};
    tv[5]  = '{1, 32'h8000_1000, 32'h0, 1'b1, 0, 1'b0, 10'd0, 32'h0};
    tv[6]  = '{0, 32'hFFFF_FFFC, 32'h0, 1'b1, 0, 1'b0, 10'd0, 32'h0};
    tv[7]  = '{0, 32'h8000_0FFC, 32'hCAFE_F00D, 1'b0, 0, 1'b0, 10'd0, 32'h0};
    tv[8]  = '{0, 32'h8000_0008, 32'h1234_5678, 1'b0, 0,
               1'b1, 10'd2, 32'hDEAD_BEEF};
    tv[9]  = '{0, 32'h8000_0008, 32'hDEAD_BEEF, 1'b0, 0, 1'b0, 10'd0, 32'h0};
    tv[10] = '{1, 32'h8000_0008, 32'hDEAD_BEEF, 1'b0, 2, 1'b0, 10'd0, 32'h0};
    tv[11] = '{1, 32'h8000_000C, em[3], 1'b0, 0, 1'b0, 10'd0, 32'h0};
    em[2] = 32'hDEAD_BEEF;

    foreach (tv[i])
      fetch(tv[i].k, tv[i].addr, tv[i].inst, tv[i].err, tv[i].hold,
            tv[i].do_ld, tv[i].la, tv[i].ld);

    // Reset while the LATENCY=3 instance is waiting.
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_addr[1]  = 32'h8000_0004;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    chk("wait_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    chk("wait_req_ready", 32'(req_ready[1]), 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    chk("midrst_req_ready", 32'(req_ready[1]), 32'd1);
    chk("midrst_inst", rsp_inst[1], 32'd0);
    @(negedge clk);
    rst = 1'b1;
    fetch(1, 32'h8000_0004, 32'h0010_0073, 1'b0, 0, 1'b0, 10'd0, 32'h0);

    // Back-to-back fetch stream over the preloaded words.
    for (int i = 0; i < 100; i++)
      fetch(0, 32'h8000_0000 + 32'((i * 7) % 16) * 4, em[(i * 7) % 16],
            1'b0, 0, 1'b0, 10'd0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
